// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch/decode widths, instruction field positions and fetch state encoding
package inst_fetch_pkg;
  localparam int INST_LEN = 17;
  localparam int PC_LEN = 5;
  localparam int PROG_DEPTH = 32;
  localparam int ALU_MSB = 16;
  localparam int ALU_LSB = 15;
  localparam int OP1_MSB = 14;
  localparam int OP1_LSB = 10;
  localparam int OP2_MSB = 9;
  localparam int OP2_LSB = 5;
  localparam int DEST_MSB = 4;
  localparam int DEST_LSB = 0;
  typedef logic [PC_LEN:0] cnt_t;
  typedef enum logic {IDLE, RUN} fetch_state_t;
endpackage

// File: rtl/inst_fetch_mem.sv
// inst_mem: program store with one synchronous write port and one registered read port
module inst_mem
  import inst_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [PC_LEN-1:0]   waddr,
  input  logic [INST_LEN-1:0] wdata,
  input  logic                re,
  input  logic [PC_LEN-1:0]   raddr,
  output logic [INST_LEN-1:0] rdata
);
  logic [INST_LEN-1:0] mem [PROG_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: walks the program memory from address 0 and hands words to decode with a valid/stall handshake
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [PC_LEN-1:0]   load_addr,
  input  logic [INST_LEN-1:0] load_data,
  input  logic [PC_LEN:0]     prog_len,
  input  logic                start,
  input  logic                stall,
  output logic [INST_LEN-1:0] inst,
  output logic                inst_valid,
  output logic [PC_LEN-1:0]   pc,
  output logic                busy,
  output logic                done
);
  fetch_state_t state, state_nxt;
  cnt_t nxt, len;
  logic accept, fetch, finish, we;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      nxt <= '0;
      len <= '0;
      pc <= '0;
      inst_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= finish;
      if (accept) begin
        nxt <= '0;
        len <= prog_len > cnt_t'(PROG_DEPTH) ? cnt_t'(PROG_DEPTH) : prog_len;
      end
      if (fetch) begin
        pc <= nxt[PC_LEN-1:0];
        nxt <= nxt + 1'b1;
        inst_valid <= 1'b1;
      end
      if (finish) inst_valid <= 1'b0;
    end
  always_comb
    state_nxt = accept ? RUN : finish ? IDLE : state;
  always_comb begin
    accept = state == IDLE && start && prog_len != '0;
    fetch = state == RUN && !stall && nxt < len;
    finish = state == RUN && !stall && nxt == len;
    we = state == IDLE && load_en && 32'(load_addr) < 32'(PROG_DEPTH);
    busy = state == RUN;
  end
  inst_mem u_mem (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(load_addr),
    .wdata(load_data),
    .re(fetch),
    .raddr(nxt[PC_LEN-1:0]),
    .rdata(inst)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors for the fetch stage, table-driven plus hand-built multi-cycle sequences
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst, load_en, start, stall;
  logic [4:0] load_addr;
  logic [16:0] load_data;
  logic [5:0] prog_len;
  logic [16:0] inst;
  logic inst_valid, busy, done;
  logic [4:0] pc;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic rst, load_en;
    logic [4:0] load_addr;
    logic [16:0] load_data;
    logic [5:0] prog_len;
    logic start, stall;
    logic [16:0] inst;
    logic valid;
    logic [4:0] pc;
    logic busy, done;
  } vec_t;

  vec_t tbl[$];
  logic [16:0] m [32];

  inst_fetch dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .stall(stall), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic le, logic [4:0] la, logic [16:0] ld, logic [5:0] pl,
                             logic st, logic sl, logic [16:0] i, logic vl, logic [4:0] p, logic b, logic d);
    vec_t x;
    x.rst = r; x.load_en = le; x.load_addr = la; x.load_data = ld; x.prog_len = pl;
    x.start = st; x.stall = sl; x.inst = i; x.valid = vl; x.pc = p; x.busy = b; x.done = d;
    return x;
  endfunction

  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    rst = x.rst; load_en = x.load_en; load_addr = x.load_addr; load_data = x.load_data;
    prog_len = x.prog_len; start = x.start; stall = x.stall;
    @(posedge clk);
    #1;
    n_vec++;
    if (inst !== x.inst || inst_valid !== x.valid || pc !== x.pc || busy !== x.busy || done !== x.done) begin
      n_bad++;
      $display("FAIL %s: got inst=%h valid=%b pc=%0d busy=%b done=%b, want inst=%h valid=%b pc=%0d busy=%b done=%b",
               nm, inst, inst_valid, pc, busy, done, x.inst, x.valid, x.pc, x.busy, x.done);
    end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0; start = 1'b0; stall = 1'b0;
    // single word, then a 4-word run with two stalled edges on word 0x2
    tbl.push_back(v(1, 0, 0, 0,        0, 0, 0, 17'h0,     0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 17'h08C85, 0, 0, 0, 17'h0,     0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,        1, 1, 0, 17'h0,     0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,        0, 0, 0, 17'h08C85, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,        0, 0, 0, 17'h08C85, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,        0, 0, 0, 17'h08C85, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, 1, 5'(k), 17'(k + 1), 0, 0, 0, 17'h08C85, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 4, 1, 0, 17'h08C85, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 17'h1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 17'h2, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 17'h2, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 17'h2, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 17'h3, 1, 2, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 17'h4, 1, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 17'h4, 0, 3, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 17'h4, 0, 3, 0, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // prog_len above depth clamps to 32 words
    for (int k = 0; k < 32; k++) begin
      m[k] = 17'(k * 2731 + 5);
      apply(v(0, 1, 5'(k), m[k], 0, 0, 0, 17'h4, 0, 3, 0, 0), "load32");
    end
    apply(v(0, 0, 0, 0, 40, 1, 0, 17'h4, 0, 3, 1, 0), "start40");
    for (int k = 0; k < 32; k++)
      apply(v(0, 0, 0, 0, 0, 0, 0, m[k], 1, 5'(k), 1, 0), $sformatf("word%0d", k));
    apply(v(0, 0, 0, 0, 0, 0, 0, m[31], 0, 31, 0, 1), "done40");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[31], 0, 31, 0, 0), "idle40");

    // zero-length start is ignored
    apply(v(0, 0, 0, 0, 0, 1, 0, m[31], 0, 31, 0, 0), "start0");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[31], 0, 31, 0, 0), "start0_idle");

    // writes during RUN are dropped, checked by a replay
    apply(v(0, 0, 0, 0,        2, 1, 0, m[31], 0, 31, 1, 0), "run_start");
    apply(v(0, 1, 0, 17'h15555, 0, 0, 0, m[0],  1, 0,  1, 0), "run_load0");
    apply(v(0, 1, 1, 17'h0AAAA, 0, 0, 0, m[1],  1, 1,  1, 0), "run_load1");
    apply(v(0, 1, 0, 17'h15555, 0, 0, 0, m[1],  0, 1,  0, 1), "run_load_done");
    apply(v(0, 0, 0, 0, 2, 1, 0, m[1], 0, 1, 1, 0), "replay_start");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[0], 1, 0, 1, 0), "replay_w0");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[1], 1, 1, 1, 0), "replay_w1");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[1], 0, 1, 0, 1), "replay_done");

    // reset mid-run, then replay from pc 0
    apply(v(0, 0, 0, 0, 4, 1, 0, m[1], 0, 1, 1, 0), "rst_start");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[0], 1, 0, 1, 0), "rst_w0");
    apply(v(0, 0, 0, 0, 0, 0, 0, m[1], 1, 1, 1, 0), "rst_w1");
    apply(v(1, 0, 0, 0, 0, 0, 0, 17'h0, 0, 0, 0, 0), "rst_hit");
    apply(v(0, 0, 0, 0, 0, 0, 0, 17'h0, 0, 0, 0, 0), "rst_nodone");
    apply(v(0, 0, 0, 0, 4, 1, 0, 17'h0, 0, 0, 1, 0), "rst_restart");
    for (int k = 0; k < 4; k++)
      apply(v(0, 0, 0, 0, 0, 0, 0, m[k], 1, 5'(k), 1, 0), $sformatf("rst_replay%0d", k));
    apply(v(0, 0, 0, 0, 0, 0, 0, m[3], 0, 3, 0, 1), "rst_replay_done");

    // load and start together, plus a stall before the first word
    apply(v(0, 1, 0, 17'h1ABCD, 1, 1, 0, m[3],     0, 3, 1, 0), "ld_start");
    apply(v(0, 0, 0, 0,         0, 0, 1, m[3],     0, 3, 1, 0), "ld_stall_first");
    apply(v(0, 0, 0, 0,         0, 0, 0, 17'h1ABCD, 1, 0, 1, 0), "ld_w0");
    apply(v(0, 0, 0, 0,         0, 0, 0, 17'h1ABCD, 0, 0, 0, 1), "ld_done");
    apply(v(0, 0, 0, 0,         0, 0, 0, 17'h1ABCD, 0, 0, 0, 0), "ld_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage: the producer for the decode stage's `inst` input. It holds a small program memory loaded through a write port. On `start` it walks the program counter from 0 and presents one `INST_LEN`-bit instruction word per advancing cycle with a valid/stall handshake, then pulses `done`. Words pass through opaque; the field layout is {alu_sig[16:15], oper1[14:10], oper2[9:5], dest[4:0]}.

## Interface
- `INST_LEN`, 17, instruction word width
- `PC_LEN`, 5, program-counter / memory address width
- `PROG_DEPTH`, 32, program memory depth (≤ 2^PC_LEN)

- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `load_en` in 1 — write `load_data` to memory at `load_addr`
- `load_addr` in PC_LEN — write address
- `load_data` in INST_LEN — write data
- `prog_len` in PC_LEN+1 — instruction count, sampled on accepted `start`
- `start` in 1 — begin fetch from address 0
- `stall` in 1 — consumer not ready; hold outputs
- `inst` out INST_LEN — instruction word to decode
- `inst_valid` out 1 — `inst` is valid
- `pc` out PC_LEN — address of the word on `inst`
- `busy` out 1 — state is RUN
- `done` out 1 — one-cycle completion pulse

## Operation
- States: IDLE, RUN. Reset → IDLE. Reset clears `inst`, `pc`, `inst_valid`, `busy`, `done`, internal counter and latched length to 0. Memory contents are not reset.
- IDLE: `load_en` writes the memory. `start` with `prog_len`≠0 latches len = min(`prog_len`, `PROG_DEPTH`), clears the next-address counter `nxt` to 0, and goes to RUN. `start` with `prog_len`=0 is ignored.
- RUN, edge with `stall`=1: nothing changes.
- RUN, edge with `stall`=0 and `nxt`<len: `inst`←mem[`nxt`], `pc`←`nxt`, `inst_valid`←1, `nxt`←`nxt`+1.
- RUN, edge with `stall`=0 and `nxt`=len: `inst_valid`←0, `done`←1, state→IDLE. `inst` and `pc` hold their last values.
- Transfer rule: a word is consumed on an edge where `inst_valid`=1 and `stall`=0.
- `load_en` outside IDLE is ignored. `start` outside IDLE is ignored.
- `load_en` and `start` in the same IDLE cycle: both take effect. The written word is readable by the first fetch.
- `load_addr` ≥ `PROG_DEPTH`: write is dropped.
- `nxt` is PC_LEN+1 bits, so it never wraps; len=32 is legal with PC_LEN=5.

## Timing
- `start` sampled at edge E0 gives word k on `inst` after edge E(k+1). First-word latency is 2 edges.
- With no stalls and N words: `inst_valid` is high for N cycles. `done`=1 for the single cycle after E(N+1), and is cleared at the next edge.
- Each stalled edge delays all later events by one cycle.
- `stall` while `inst_valid`=0 in RUN (before the first word) also blocks the fetch.
- Reset mid-RUN: IDLE and all outputs 0 at the next edge. No `done` is generated.
- `busy` is registered: high from E0 through the edge that raises `done`.

## Structure
- Shared package holds: `INST_LEN`, `PC_LEN`, field MSB/LSB constants (ALU 16:15, OP1 14:10, OP2 9:5, DEST 4:0), and the fetch state enum. The decode stage uses the same field constants.
- One sub-module, `inst_mem`: PROG_DEPTH×INST_LEN, one synchronous write port, one synchronous read port with read enable = RUN & !stall & `nxt`<len.

## Test plan
- Load mem[0]=0x08C85 (alu=1, oper1=3, oper2=4, dest=5), `prog_len`=1, `start` → after E1 `inst`=0x08C85, `pc`=0, `inst_valid`=1; after E2 `inst_valid`=0, `done`=1; after E3 `done`=0.
- Load mem[0..3]=0x1,0x2,0x3,0x4, `prog_len`=4, `stall` high for 2 cycles while `inst`=0x2 → 0x2 is held 3 cycles, each word is transferred exactly once, `done` arrives 2 cycles later than the no-stall run.
- `prog_len`=40 → fetch stops after 32 words, last `pc`=31, then `done`.
- `prog_len`=0 with `start` → stays IDLE, `busy`=0, no `done`. `load_en` during RUN → memory unchanged, checked by a second run.
- Assert `rst` after 2 words of a 4-word run → next cycle all outputs 0, no `done`. A new `start` replays from `pc`=0 with the memory intact.
- `load_en`(addr 0, 0x1ABCD) and `start` in the same cycle → first `inst`=0x1ABCD.
